hazard_forward_unit: RTL

- Parametrised hazard/forwarding controller for the 5-stage MIPS core (F/D/E/M/W); successor to the combinational forwarding logic.
- Tracks its own E/M/W destination records with per-stage Tnew countdown.
- Generates the D-stage stall from a Tuse/Tnew comparison, forwarding selects for D, E and M operands, and a mult/div busy counter that stalls HI/LO users.

---
 rtl/hazard_forward_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: tracks E/M/W
// destination records, raises the D-stage stall and drives operand forwarding selects.
module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int TW       = 2,
  parameter int SD_IDX   = 1,
  parameter int CW       = 4,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [NRD*AW-1:0]   d_rs,
  input  logic [NRD-1:0]      d_rs_en,
  input  logic [NRD*TW-1:0]   d_tuse,
  input  logic [AW-1:0]       d_a3,
  input  logic                d_regwr,
  input  logic [TW-1:0]       d_tnew,
  input  logic                d_md_start,
  input  logic                d_md_div,
  input  logic                d_md_use,
  output logic                stall,
  output logic [NRD*2-1:0]    fwd_d,
  output logic [NRD*2-1:0]    fwd_e,
  output logic                fwd_m,
  output logic                md_busy
);

  localparam logic [AW-1:0] REG_ZERO  = {AW{1'b0}};
  localparam logic [TW-1:0] TNEW_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TNEW_ONE  = TW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] MULT_CNT  = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT   = CW'(DIV_LAT);
  localparam logic [1:0]    SEL_RF    = 2'd0;
  localparam logic [1:0]    SEL_E     = 2'd1;
  localparam logic [1:0]    SEL_M     = 2'd2;
  localparam logic [1:0]    SEL_W     = 2'd3;

  // Tnew counts down one per stage and saturates at zero (result ready).
  function automatic logic [TW-1:0] tnew_step(input logic [TW-1:0] t);
    return (t == TNEW_ZERO) ? TNEW_ZERO : t - TNEW_ONE;
  endfunction

  logic                e_valid_r, e_regwr_r, e_md_start_r, e_md_div_r;
  logic [AW-1:0]       e_a3_r;
  logic [TW-1:0]       e_tnew_r;
  logic [NRD*AW-1:0]   e_rs_r;
  logic [NRD-1:0]      e_rs_en_r;
  logic                m_valid_r, m_regwr_r, m_sd_en_r;
  logic [AW-1:0]       m_a3_r, m_sd_r;
  logic [TW-1:0]       m_tnew_r;
  logic                w_valid_r, w_regwr_r;
  logic [AW-1:0]       w_a3_r;
  logic [CW-1:0]       cnt_r;

  logic                e_wr_s, m_wr_s, w_wr_s;
  logic                md_start_e_s, md_busy_s, md_stall_s, stall_s;
  logic [NRD-1:0]      data_stall_s;

  // Register $0 is excluded here, so it can never match, stall or forward.
  assign e_wr_s = e_valid_r && e_regwr_r && (e_a3_r != REG_ZERO);
  assign m_wr_s = m_valid_r && m_regwr_r && (m_a3_r != REG_ZERO);
  assign w_wr_s = w_valid_r && w_regwr_r && (w_a3_r != REG_ZERO);

  for (genvar i = 0; i < NRD; i++) begin : g_op
    logic [AW-1:0] rs_s, ers_s;
    logic [TW-1:0] tuse_s;
    logic          e_hit_s, m_hit_s, w_hit_s, em_hit_s, ew_hit_s;

    assign rs_s   = d_rs[i*AW +: AW];
    assign tuse_s = d_tuse[i*TW +: TW];
    assign ers_s  = e_rs_r[i*AW +: AW];

    assign e_hit_s = e_wr_s && (e_a3_r == rs_s);
    assign m_hit_s = m_wr_s && (m_a3_r == rs_s);
    assign w_hit_s = w_wr_s && (w_a3_r == rs_s);

    assign data_stall_s[i] = d_valid && d_rs_en[i] && (rs_s != REG_ZERO) &&
                             ((e_hit_s && (e_tnew_r > tuse_s)) ||
                              (m_hit_s && (m_tnew_r > tuse_s)));

    // Youngest ready producer wins: E before M before W.
    assign fwd_d[i*2 +: 2] = !d_rs_en[i]                          ? SEL_RF :
                             (e_hit_s && (e_tnew_r == TNEW_ZERO)) ? SEL_E  :
                             (m_hit_s && (m_tnew_r == TNEW_ZERO)) ? SEL_M  :
                             w_hit_s                              ? SEL_W  : SEL_RF;

    assign em_hit_s = m_wr_s && (m_a3_r == ers_s) && (m_tnew_r == TNEW_ZERO);
    assign ew_hit_s = w_wr_s && (w_a3_r == ers_s);

    // A bubble in E carries no operands, so it never requests forwarding.
    assign fwd_e[i*2 +: 2] = !(e_valid_r && e_rs_en_r[i]) ? SEL_RF :
                             em_hit_s                     ? SEL_M  :
                             ew_hit_s                     ? SEL_W  : SEL_RF;
  end

  assign fwd_m = m_valid_r && m_sd_en_r && w_wr_s && (w_a3_r == m_sd_r);

  assign md_start_e_s = e_valid_r && e_md_start_r;
  assign md_busy_s    = md_start_e_s || (cnt_r != CNT_ZERO);
  assign md_stall_s   = d_valid && (d_md_use || d_md_start) && md_busy_s;
  assign stall_s      = (|data_stall_s) || md_stall_s;

  assign stall   = stall_s;
  assign md_busy = md_busy_s;

  // Stage records: E loads D (or a bubble on stall), M and W follow unconditionally.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_r    <= 1'b0;
      e_regwr_r    <= 1'b0;
      e_md_start_r <= 1'b0;
      e_md_div_r   <= 1'b0;
      e_a3_r       <= REG_ZERO;
      e_tnew_r     <= TNEW_ZERO;
      e_rs_r       <= {(NRD*AW){1'b0}};
      e_rs_en_r    <= {NRD{1'b0}};
      m_valid_r    <= 1'b0;
      m_regwr_r    <= 1'b0;
      m_sd_en_r    <= 1'b0;
      m_a3_r       <= REG_ZERO;
      m_sd_r       <= REG_ZERO;
      m_tnew_r     <= TNEW_ZERO;
      w_valid_r    <= 1'b0;
      w_regwr_r    <= 1'b0;
      w_a3_r       <= REG_ZERO;
    end else begin
      e_valid_r    <= d_valid && !stall_s;
      e_regwr_r    <= d_regwr;
      e_md_start_r <= d_md_start;
      e_md_div_r   <= d_md_div;
      e_a3_r       <= d_a3;
      e_tnew_r     <= d_tnew;
      e_rs_r       <= d_rs;
      e_rs_en_r    <= d_rs_en;
      m_valid_r    <= e_valid_r;
      m_regwr_r    <= e_regwr_r;
      m_sd_en_r    <= e_rs_en_r[SD_IDX];
      m_a3_r       <= e_a3_r;
      m_sd_r       <= e_rs_r[SD_IDX*AW +: AW];
      m_tnew_r     <= tnew_step(e_tnew_r);
      w_valid_r    <= m_valid_r;
      w_regwr_r    <= m_regwr_r;
      w_a3_r       <= m_a3_r;
    end
  end

  // Mult/div occupancy counter, loaded when the operation sits in E.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (md_start_e_s) begin
      cnt_r <= e_md_div_r ? DIV_CNT : MULT_CNT;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
